// File: rtl/gfx_cmd_defs.sv
// gfx_cmd_defs: shared command-stream definitions for the graphics front end.
// Opcode constants, command-word field positions, screen geometry, FSM state
// encoding for the line sequencer and a small coordinate clamp helper.
package gfx_cmd_defs;

    localparam logic [7:0] OP_NOP_C  = 8'h00;
    localparam logic [7:0] OP_LINE_C = 8'h01;

    // Header word: {op, rgb}
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 24;
    localparam int RGB_MSB = 23;
    localparam int RGB_LSB = 0;

    // Point word: {6'b0, x[25:16], 6'b0, y[9:0]}
    localparam int X_MSB = 25;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 9;
    localparam int Y_LSB = 0;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        GET_P0     = 4'd1,
        GET_P1     = 4'd2,
        WAIT_LE    = 4'd3,
        S_COLOR    = 4'd4,
        S_X0       = 4'd5,
        S_Y0       = 4'd6,
        S_X1       = 4'd7,
        S_Y1       = 4'd8,
        WAIT_START = 4'd9,
        WAIT_DONE  = 4'd10
    } seq_state_e;

    // Saturate a 10-bit coordinate at lim.
    function automatic logic [9:0] clamp_coord(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: synchronous first-word-fall-through FIFO for command words.
// full/empty are registered; a push is ignored while full, a pop while empty.
module line_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1'b1);
    localparam logic [AW:0]    CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = full_r;
    assign empty = empty_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests against the registered flags and compute the next occupancy.
    always_comb begin
        push_ok_s    = push && !full_r;
        pop_ok_s     = pop && !empty_r;
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array; contents need no reset since empty_r guards every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_MAX);
            empty_r <= (count_next_s == '0);
        end
    end

endmodule

// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer: buffers CPU command words, decodes LINE commands and
// replays them onto the line engine config port as one strobe per cycle,
// trigger alongside y1, then waits for the engine to finish the draw.
// Build option: define LINE_SEQ_CLAMP_EN to clamp y0/y1 to Y_MAX when latched.
module line_cmd_sequencer
    import gfx_cmd_defs::*;
#(
    parameter int         CMD_DEPTH = 4,
    parameter logic [9:0] Y_MAX     = 10'd767,
    parameter logic [7:0] OP_NOP    = OP_NOP_C,
    parameter logic [7:0] OP_LINE   = OP_LINE_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        LE_ready,
    output logic [31:0] LE_color,
    output logic [9:0]  LE_point,
    output logic        LE_color_valid,
    output logic        LE_x0_valid,
    output logic        LE_y0_valid,
    output logic        LE_x1_valid,
    output logic        LE_y1_valid,
    output logic        LE_trigger,
    output logic        seq_idle,
    output logic        err_bad_op,
    input  logic        err_clear,
    output logic [15:0] lines_done
);

    seq_state_e  state_r;
    seq_state_e  state_next_s;
    logic [31:0] fifo_dout_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        fifo_pop_s;
    logic [7:0]  hdr_op_s;
    logic        line_hdr_s;
    logic        bad_op_s;
    logic        lat_p0_s;
    logic        lat_p1_s;
    logic        draw_done_s;
    logic        reserved_unused_s;

    logic [23:0] rgb_r;
    logic [9:0]  x0_r, y0_r, x1_r, y1_r;
    logic [31:0] color_r;
    logic [9:0]  point_r;
    logic        color_valid_r, x0_valid_r, y0_valid_r, x1_valid_r, y1_valid_r, trigger_r;
    logic        seq_idle_r;
    logic        err_r;
    logic [15:0] lines_done_r;

    // y coordinate as it is latched: saturated only when clamping is built in.
    function automatic logic [9:0] fix_y(input logic [9:0] y);
`ifdef LINE_SEQ_CLAMP_EN
        return clamp_coord(y, Y_MAX);
`else
        return y;
`endif
    endfunction

    line_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cmd_data),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign hdr_op_s          = fifo_dout_s[OP_MSB:OP_LSB];
    assign reserved_unused_s = ^{fifo_dout_s[31:26], fifo_dout_s[15:10]};

    assign cmd_ready      = !fifo_full_s;
    assign LE_color       = color_r;
    assign LE_point       = point_r;
    assign LE_color_valid = color_valid_r;
    assign LE_x0_valid    = x0_valid_r;
    assign LE_y0_valid    = y0_valid_r;
    assign LE_x1_valid    = x1_valid_r;
    assign LE_y1_valid    = y1_valid_r;
    assign LE_trigger     = trigger_r;
    assign seq_idle       = seq_idle_r;
    assign err_bad_op     = err_r;
    assign lines_done     = lines_done_r;

    // Next-state decode, FIFO pops and latch enables.
    always_comb begin
        state_next_s = state_r;
        fifo_pop_s   = 1'b0;
        line_hdr_s   = 1'b0;
        bad_op_s     = 1'b0;
        lat_p0_s     = 1'b0;
        lat_p1_s     = 1'b0;
        draw_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    if (hdr_op_s == OP_LINE) begin
                        line_hdr_s   = 1'b1;
                        state_next_s = GET_P0;
                    end else if (hdr_op_s == OP_NOP) begin
                        state_next_s = IDLE;
                    end else begin
                        bad_op_s     = 1'b1;
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            GET_P0: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s   = 1'b1;
                    lat_p0_s     = 1'b1;
                    state_next_s = GET_P1;
                end else begin
                    state_next_s = GET_P0;
                end
            end
            GET_P1: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s   = 1'b1;
                    lat_p1_s     = 1'b1;
                    state_next_s = WAIT_LE;
                end else begin
                    state_next_s = GET_P1;
                end
            end
            WAIT_LE: begin
                if (LE_ready) begin
                    state_next_s = S_COLOR;
                end else begin
                    state_next_s = WAIT_LE;
                end
            end
            S_COLOR:    state_next_s = S_X0;
            S_X0:       state_next_s = S_Y0;
            S_Y0:       state_next_s = S_X1;
            S_X1:       state_next_s = S_Y1;
            S_Y1:       state_next_s = WAIT_START;
            WAIT_START: state_next_s = WAIT_DONE;
            WAIT_DONE: begin
                if (LE_ready) begin
                    draw_done_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command field latches: colour on the header, endpoints on the point words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 24'd0;
            x0_r  <= 10'd0;
            y0_r  <= 10'd0;
            x1_r  <= 10'd0;
            y1_r  <= 10'd0;
        end else begin
            if (line_hdr_s) begin
                rgb_r <= fifo_dout_s[RGB_MSB:RGB_LSB];
            end
            if (lat_p0_s) begin
                x0_r <= fifo_dout_s[X_MSB:X_LSB];
                y0_r <= fix_y(fifo_dout_s[Y_MSB:Y_LSB]);
            end
            if (lat_p1_s) begin
                x1_r <= fifo_dout_s[X_MSB:X_LSB];
                y1_r <= fix_y(fifo_dout_s[Y_MSB:Y_LSB]);
            end
        end
    end

    // Strobes are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_valid_r <= 1'b0;
            x0_valid_r    <= 1'b0;
            y0_valid_r    <= 1'b0;
            x1_valid_r    <= 1'b0;
            y1_valid_r    <= 1'b0;
            trigger_r     <= 1'b0;
        end else begin
            color_valid_r <= (state_next_s == S_COLOR);
            x0_valid_r    <= (state_next_s == S_X0);
            y0_valid_r    <= (state_next_s == S_Y0);
            x1_valid_r    <= (state_next_s == S_X1);
            y1_valid_r    <= (state_next_s == S_Y1);
            trigger_r     <= (state_next_s == S_Y1);
        end
    end

    // Colour and point data; both hold outside their strobe cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_r <= 32'd0;
            point_r <= 10'd0;
        end else begin
            case (state_next_s)
                S_COLOR: color_r <= {8'h00, rgb_r};
                S_X0:    point_r <= x0_r;
                S_Y0:    point_r <= y0_r;
                S_X1:    point_r <= x1_r;
                S_Y1:    point_r <= y1_r;
                default: point_r <= point_r;
            endcase
        end
    end

    // Status: idle flag, sticky bad-opcode flag (set beats clear), line counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_idle_r   <= 1'b1;
            err_r        <= 1'b0;
            lines_done_r <= 16'd0;
        end else begin
            seq_idle_r <= fifo_empty_s && (state_r == IDLE);
            if (bad_op_s) begin
                err_r <= 1'b1;
            end else if (err_clear) begin
                err_r <= 1'b0;
            end
            if (draw_done_s) begin
                lines_done_r <= lines_done_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// tb_line_cmd_sequencer: scoreboard bench. Stimulus pushes command words; a
// command-level model turns the accepted word stream into expected lines that
// a monitor compares against the engine-side strobes. A small engine model
// drops LE_ready for a random time after each trigger.
module tb_line_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        LE_ready;
    logic [31:0] LE_color;
    logic [9:0]  LE_point;
    logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger;
    logic        seq_idle;
    logic        err_bad_op;
    logic        err_clear = 1'b0;
    logic [15:0] lines_done;

    typedef struct {
        logic [31:0] color;
        logic [9:0]  x0, y0, x1, y1;
    } line_t;

    line_t       exp_q[$];
    logic [31:0] pend_q[$];
    line_t       cur;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lines_exp = 0;
    bit          exp_err = 1'b0;
    bit          saw_full = 1'b0;
    bit          hold_off = 1'b0;
    int          busy = 0;
    int          phase = 0;

    always #5 clk = ~clk;

    assign LE_ready = !hold_off && (busy == 0);

    line_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
        .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
        .seq_idle(seq_idle), .err_bad_op(err_bad_op), .err_clear(err_clear), .lines_done(lines_done)
    );

    function automatic logic [9:0] ref_y(input logic [9:0] y);
`ifdef LINE_SEQ_CLAMP_EN
        return (y > 10'd767) ? 10'd767 : y;
`else
        return y;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Command-level model: consume accepted words and emit expected lines.
    function automatic void model_word(input logic [31:0] w);
        bit         go;
        logic [7:0] op;
        line_t      l;
        pend_q.push_back(w);
        go = 1'b1;
        while (go && pend_q.size() > 0) begin
            op = pend_q[0][31:24];
            if (op == 8'h00) begin
                void'(pend_q.pop_front());
            end else if (op == 8'h01) begin
                if (pend_q.size() >= 3) begin
                    l.color = {8'h00, pend_q[0][23:0]};
                    l.x0 = pend_q[1][25:16];
                    l.y0 = ref_y(pend_q[1][9:0]);
                    l.x1 = pend_q[2][25:16];
                    l.y1 = ref_y(pend_q[2][9:0]);
                    exp_q.push_back(l);
                    lines_exp++;
                    repeat (3) void'(pend_q.pop_front());
                end else begin
                    go = 1'b0;
                end
            end else begin
                exp_err = 1'b1;
                void'(pend_q.pop_front());
            end
        end
    endfunction

    task automatic push_word(input logic [31:0] w, input int gap);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = w;
        while (!done) begin
            if (cmd_ready) begin
                @(posedge clk);
                done = 1'b1;
                model_word(w);
            end else begin
                saw_full = 1'b1;
                t++;
                if (t > 2000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL push_timeout: word %h not accepted", w);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push_line(input logic [23:0] rgb, input logic [9:0] x0, input logic [9:0] y0,
                             input logic [9:0] x1, input logic [9:0] y1, input int gap);
        push_word({8'h01, rgb}, gap);
        push_word({6'd0, x0, 6'd0, y0}, gap);
        push_word({6'd0, x1, 6'd0, y1}, gap);
    endtask

    task automatic drain(input string name);
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        while (quiet < 3 && t < 3000) begin
            @(negedge clk);
            t++;
            if (seq_idle && exp_q.size() == 0 && phase == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain: timeout, %0d lines still expected", name, exp_q.size());
        end
    endtask

    // Engine model: busy for a random time after each trigger.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) busy = 0;
            else if (LE_trigger) busy = $urandom_range(1, 6);
            else if (busy > 0) busy--;
        end
    end

    // Monitor: compares each strobe sequence with the next expected line.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
            end else if (phase == 0) begin
                if (LE_color_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_line: color %h with no line expected", LE_color);
                    end else begin
                        cur = exp_q.pop_front();
                        check("color", LE_color, cur.color);
                    end
                    phase = 1;
                end else if (LE_x0_valid | LE_y0_valid | LE_x1_valid | LE_y1_valid | LE_trigger) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stray_strobe: strobes %b outside a line", {LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger});
                end
            end else begin
                case (phase)
                    1: begin
                        check("strobe_x0", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'b010000);
                        check("point_x0", LE_point, cur.x0);
                    end
                    2: begin
                        check("strobe_y0", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'b001000);
                        check("point_y0", LE_point, cur.y0);
                    end
                    3: begin
                        check("strobe_x1", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'b000100);
                        check("point_x1", LE_point, cur.x1);
                    end
                    default: begin
                        check("strobe_y1_trig", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'b000011);
                        check("point_y1", LE_point, cur.y1);
                    end
                endcase
                phase = (phase == 4) ? 0 : phase + 1;
            end
        end
    end

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int t;
        int r;
        logic [7:0] bad;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_strobes", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'd0);
        check("rst_cmd_ready", cmd_ready, 32'd1);
        check("rst_seq_idle", seq_idle, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_color", LE_color, 32'd0);
        check("rst_point", LE_point, 32'd0);
        check("rst_err", err_bad_op, 32'd0);
        check("rst_lines_done", lines_done, 32'd0);

        // Basic line, y at the last visible row
        push_line(24'h7F0000, 10'd0, 10'd0, 10'd1023, 10'd767, 0);
        drain("basic");
        check("lines_done_basic", lines_done, lines_exp);

        // Engine busy before the header: no strobes until LE_ready rises
        hold_off = 1'b1;
        push_line(24'h00FF00, 10'd5, 10'd6, 10'd7, 10'd8, 0);
        repeat (12) @(negedge clk);
        check("hold_no_strobe", exp_q.size(), 32'd1);
        hold_off = 1'b0;
        @(negedge clk);
        check("color_after_ready", LE_color_valid, 32'd1);
        drain("hold");

        // Five back-to-back lines: FIFO fills, nothing lost
        saw_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_line($urandom, 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 0);
        end
        check("cmd_ready_dropped", saw_full, 32'd1);
        drain("burst");
        check("lines_done_burst", lines_done, lines_exp);

        // Unknown opcode dropped, following line draws, clear drops the flag
        push_word(32'h7E123456, 0);
        push_line(24'h0000FF, 10'd300, 10'd200, 10'd300, 10'd200, 0);
        drain("bad_op");
        check("err_set", err_bad_op, exp_err);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_err = 1'b0;
        check("err_cleared", err_bad_op, exp_err);

        // y beyond the visible range
        push_line(24'h123456, 10'd1023, 10'd1000, 10'd512, 10'd900, 1);
        drain("y_range");

        // Random mix of NOP, LINE and bad opcodes with reserved bits set
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                push_word({8'h00, 24'($urandom)}, $urandom_range(0, 2));
            end else if (r == 2) begin
                bad = 8'($urandom_range(2, 255));
                push_word({bad, 24'($urandom)}, $urandom_range(0, 2));
            end else begin
                push_word({8'h01, 24'($urandom)}, $urandom_range(0, 2));
                push_word($urandom, $urandom_range(0, 2));
                push_word($urandom, $urandom_range(0, 2));
            end
        end
        drain("random");
        check("err_random", err_bad_op, exp_err);
        check("lines_done_random", lines_done, lines_exp);

        // Reset in the middle of a draw
        push_line(24'hABCDEF, 10'd11, 10'd22, 10'd33, 10'd44, 0);
        t = 0;
        @(negedge clk);
        while (!LE_x1_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("reached_x1", LE_x1_valid, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_strobes", {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger}, 32'd0);
        check("midrst_cmd_ready", cmd_ready, 32'd1);
        check("midrst_seq_idle", seq_idle, 32'd1);
        check("midrst_lines_done", lines_done, 32'd0);
        exp_q.delete();
        pend_q.delete();
        lines_exp = 0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_line(24'h010203, 10'd100, 10'd100, 10'd100, 10'd100, 0);
        drain("after_reset");
        check("lines_done_after_reset", lines_done, lines_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
